ringctr_param: RTL and testbench

Parametrised, self-correcting shift-register counter: the generalised successor to the fixed 4-bit ring counter. It supports ring (one-hot) and Johnson (twisted-ring) modes, both shift directions, clock enable, parallel load and illegal-state recovery. It registers its own state and still exposes the combinational next state `qn`, so existing sequencer and strobe-generation logic can migrate to it.

---
 rtl/ringctr_pkg.sv | 20 ++
 rtl/ringctr_legal.sv | 28 ++
 rtl/ringctr_param.sv | 81 ++++++++
 tb/tb_ringctr_param.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ringctr_pkg.sv
// Shared constants and helpers for the parametrised ring/Johnson counter.
package ringctr_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_JOHNSON = 1'b1;
  localparam logic DIR_UP       = 1'b0;
  localparam logic DIR_DOWN     = 1'b1;

  // Widest counter the home-state helper can describe; callers cast down to WIDTH.
  localparam int MAX_WIDTH = 64;

  // Home state: 0...01 in ring mode, all-zeros in Johnson mode.
  function automatic logic [MAX_WIDTH-1:0] home_state(input logic mode, input int width);
    home_state = '0;
    if ((mode == MODE_RING) && (width >= 1)) begin
      home_state[0] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/ringctr_legal.sv
// Combinational legality check of a counter state under the selected mode.
module ringctr_legal
  import ringctr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             mode,
  output logic             legal
);

  int ones;
  int edges;

  // Ring states are one-hot; Johnson states have at most one 0/1 boundary.
  always_comb begin
    ones  = 0;
    edges = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (q[i]) ones = ones + 1;
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (q[i] != q[i+1]) edges = edges + 1;
    end
    legal = (mode == MODE_RING) ? (ones == 1) : (edges <= 1);
  end

endmodule

// File: rtl/ringctr_param.sv
// Parametrised self-correcting ring / Johnson counter with load and enable.
// qn exposes the next-state mux so downstream strobe logic can look ahead.
module ringctr_param
  import ringctr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             wrap,
  output logic             illegal
);

  logic             legal;
  logic [WIDTH-1:0] home;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             illegal_nxt;

  ringctr_legal #(.WIDTH(WIDTH)) u_legal (
    .q     (q),
    .mode  (mode),
    .legal (legal)
  );

  assign home = WIDTH'(home_state(mode, WIDTH));

  // One-step advance of a legal state; down is the exact inverse of up.
  always_comb begin
    shifted = q;
    if (mode == MODE_RING) begin
      if (dir == DIR_UP) shifted = {q[WIDTH-2:0], q[WIDTH-1]};
      else               shifted = {q[0], q[WIDTH-1:1]};
    end else begin
      if (dir == DIR_UP) shifted = {q[WIDTH-2:0], ~q[WIDTH-1]};
      else               shifted = {~q[0], q[WIDTH-1:1]};
    end
  end

  // Next-state mux: load beats advance beats hold; illegal states snap to home.
  always_comb begin
    q_nxt       = q;
    wrap_nxt    = 1'b0;
    illegal_nxt = 1'b0;
    if (load) begin
      q_nxt = load_val;
    end else if (en) begin
      if (legal) begin
        q_nxt    = shifted;
        wrap_nxt = (shifted == home);
      end else begin
        q_nxt       = home;
        illegal_nxt = 1'b1;
      end
    end
  end

  assign qn = q_nxt;

  // State register and the two status pulse flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q       <= {{(WIDTH-1){1'b0}}, 1'b1};
      wrap    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      q       <= q_nxt;
      wrap    <= wrap_nxt;
      illegal <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_ringctr_param.sv
// Scenario bench for ringctr_param at WIDTH = 4 using a queue of per-edge
// stimulus plus expected outputs taken from the counter's defined sequences.
module tb_ringctr_param;
  import ringctr_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, en, mode, dir, load;
  logic [W-1:0] load_val, q, qn;
  logic         wrap, illegal;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         en;
    logic         load;
    logic [W-1:0] lv;
    logic         mode;
    logic         dir;
    logic [W-1:0] q;
    logic         wrap;
    logic         ill;
  } item_t;

  item_t sb[$];
  item_t it;

  ringctr_param #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .qn       (qn),
    .wrap     (wrap),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  function automatic void push(logic e, logic ld, logic [W-1:0] lv, logic md, logic dr,
                               logic [W-1:0] xq, logic xw, logic xi);
    item_t t;
    t.en = e; t.load = ld; t.lv = lv; t.mode = md; t.dir = dr;
    t.q = xq; t.wrap = xw; t.ill = xi;
    sb.push_back(t);
  endfunction

  task test_reset();
    reset = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; mode = MODE_RING; dir = DIR_UP;
    push(1'b0, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b0001, 1'b0, 1'b0);
    #2;
    it = sb.pop_front();
    checks++;
    if ({q, wrap, illegal} !== {it.q, it.wrap, it.ill}) begin
      errors++;
      $display("FAIL reset: q/wrap/illegal got %b/%b/%b want %b/%b/%b", q, wrap, illegal, it.q, it.wrap, it.ill);
    end
    checks++;
    if (qn !== it.q) begin
      errors++;
      $display("FAIL reset_qn: got %b want %b", qn, it.q);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task test_ring_up();
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b0010, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b0100, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b1000, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b0001, 1'b1, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b0010, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      en = it.en; load = it.load; load_val = it.lv; mode = it.mode; dir = it.dir;
      #1;
      checks++;
      if (qn !== it.q) begin
        errors++;
        $display("FAIL ring_up_qn: got %b want %b", qn, it.q);
      end
      @(posedge clk); #1;
      checks++;
      if ({q, wrap, illegal} !== {it.q, it.wrap, it.ill}) begin
        errors++;
        $display("FAIL ring_up: q/wrap/illegal got %b/%b/%b want %b/%b/%b", q, wrap, illegal, it.q, it.wrap, it.ill);
      end
    end
  endtask

  task test_johnson_up();
    push(1'b0, 1'b1, 4'b0000, MODE_JOHNSON, DIR_UP, 4'b0000, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_JOHNSON, DIR_UP, 4'b0001, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_JOHNSON, DIR_UP, 4'b0011, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_JOHNSON, DIR_UP, 4'b0111, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_JOHNSON, DIR_UP, 4'b1111, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_JOHNSON, DIR_UP, 4'b1110, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_JOHNSON, DIR_UP, 4'b1100, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_JOHNSON, DIR_UP, 4'b1000, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_JOHNSON, DIR_UP, 4'b0000, 1'b1, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_JOHNSON, DIR_UP, 4'b0001, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_JOHNSON, DIR_DOWN, 4'b0000, 1'b1, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_JOHNSON, DIR_DOWN, 4'b1000, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      en = it.en; load = it.load; load_val = it.lv; mode = it.mode; dir = it.dir;
      #1;
      checks++;
      if (qn !== it.q) begin
        errors++;
        $display("FAIL johnson_qn: got %b want %b", qn, it.q);
      end
      @(posedge clk); #1;
      checks++;
      if ({q, wrap, illegal} !== {it.q, it.wrap, it.ill}) begin
        errors++;
        $display("FAIL johnson: q/wrap/illegal got %b/%b/%b want %b/%b/%b", q, wrap, illegal, it.q, it.wrap, it.ill);
      end
    end
  endtask

  task test_ring_down();
    push(1'b0, 1'b1, 4'b0001, MODE_RING, DIR_DOWN, 4'b0001, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_DOWN, 4'b1000, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_DOWN, 4'b0100, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_DOWN, 4'b0010, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_DOWN, 4'b0001, 1'b1, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_DOWN, 4'b1000, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_UP,   4'b0001, 1'b1, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_UP,   4'b0010, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_DOWN, 4'b0001, 1'b1, 1'b0);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      en = it.en; load = it.load; load_val = it.lv; mode = it.mode; dir = it.dir;
      #1;
      checks++;
      if (qn !== it.q) begin
        errors++;
        $display("FAIL ring_down_qn: got %b want %b", qn, it.q);
      end
      @(posedge clk); #1;
      checks++;
      if ({q, wrap, illegal} !== {it.q, it.wrap, it.ill}) begin
        errors++;
        $display("FAIL ring_down: q/wrap/illegal got %b/%b/%b want %b/%b/%b", q, wrap, illegal, it.q, it.wrap, it.ill);
      end
    end
  endtask

  task test_illegal();
    push(1'b0, 1'b1, 4'b0110, MODE_RING,    DIR_UP, 4'b0110, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING,    DIR_UP, 4'b0001, 1'b0, 1'b1);
    push(1'b0, 1'b1, 4'b0101, MODE_JOHNSON, DIR_UP, 4'b0101, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_JOHNSON, DIR_UP, 4'b0000, 1'b0, 1'b1);
    push(1'b1, 1'b0, 4'b0000, MODE_RING,    DIR_UP, 4'b0001, 1'b0, 1'b1);
    push(1'b0, 1'b1, 4'b0000, MODE_RING,    DIR_DOWN, 4'b0000, 1'b0, 1'b0);
    push(1'b0, 1'b0, 4'b0000, MODE_RING,    DIR_DOWN, 4'b0000, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING,    DIR_DOWN, 4'b0001, 1'b0, 1'b1);
    push(1'b1, 1'b0, 4'b0000, MODE_RING,    DIR_DOWN, 4'b1000, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      en = it.en; load = it.load; load_val = it.lv; mode = it.mode; dir = it.dir;
      #1;
      checks++;
      if (qn !== it.q) begin
        errors++;
        $display("FAIL illegal_qn: got %b want %b", qn, it.q);
      end
      @(posedge clk); #1;
      checks++;
      if ({q, wrap, illegal} !== {it.q, it.wrap, it.ill}) begin
        errors++;
        $display("FAIL illegal: q/wrap/illegal got %b/%b/%b want %b/%b/%b", q, wrap, illegal, it.q, it.wrap, it.ill);
      end
    end
  endtask

  task test_load_hold();
    push(1'b1, 1'b1, 4'b0100, MODE_RING, DIR_UP, 4'b0100, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b1000, 1'b0, 1'b0);
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b0001, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 1'b0, 4'b1010, MODE_RING, DIR_UP, 4'b0001, 1'b0, 1'b0);
    end
    push(1'b1, 1'b1, 4'b1010, MODE_RING, DIR_UP, 4'b1010, 1'b0, 1'b0);
    push(1'b0, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b1010, 1'b0, 1'b0);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      en = it.en; load = it.load; load_val = it.lv; mode = it.mode; dir = it.dir;
      #1;
      checks++;
      if (qn !== it.q) begin
        errors++;
        $display("FAIL load_hold_qn: got %b want %b", qn, it.q);
      end
      @(posedge clk); #1;
      checks++;
      if ({q, wrap, illegal} !== {it.q, it.wrap, it.ill}) begin
        errors++;
        $display("FAIL load_hold: q/wrap/illegal got %b/%b/%b want %b/%b/%b", q, wrap, illegal, it.q, it.wrap, it.ill);
      end
    end
  endtask

  task test_async_reset();
    // Reach 1000 mid-count, then hit reset between edges.
    en = 1'b1; load = 1'b1; load_val = 4'b0100; mode = MODE_RING; dir = DIR_UP;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    push(1'b0, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b0001, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    it = sb.pop_front();
    checks++;
    if ({q, wrap, illegal} !== {it.q, it.wrap, it.ill}) begin
      errors++;
      $display("FAIL async_reset_mid: q/wrap/illegal got %b/%b/%b want %b/%b/%b", q, wrap, illegal, it.q, it.wrap, it.ill);
    end
    @(posedge clk); #1;
    reset = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b0010, 1'b0, 1'b0);
    it = sb.pop_front();
    checks++;
    if ({q, wrap, illegal} !== {it.q, it.wrap, it.ill}) begin
      errors++;
      $display("FAIL async_reset_first_adv: q/wrap/illegal got %b/%b/%b want %b/%b/%b", q, wrap, illegal, it.q, it.wrap, it.ill);
    end
    // Advance to a wrap pulse, then reset must clear it without an edge.
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    push(1'b1, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b0001, 1'b1, 1'b0);
    push(1'b0, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b0001, 1'b0, 1'b0);
    push(1'b0, 1'b0, 4'b0000, MODE_RING, DIR_UP, 4'b0001, 1'b0, 1'b0);
    it = sb.pop_front();
    checks++;
    if ({q, wrap, illegal} !== {it.q, it.wrap, it.ill}) begin
      errors++;
      $display("FAIL async_reset_prewrap: q/wrap/illegal got %b/%b/%b want %b/%b/%b", q, wrap, illegal, it.q, it.wrap, it.ill);
    end
    en = 1'b0;
    reset = 1'b1;
    #2;
    it = sb.pop_front();
    checks++;
    if ({q, wrap, illegal} !== {it.q, it.wrap, it.ill}) begin
      errors++;
      $display("FAIL async_reset_wrap_clear: q/wrap/illegal got %b/%b/%b want %b/%b/%b", q, wrap, illegal, it.q, it.wrap, it.ill);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    it = sb.pop_front();
    checks++;
    if ({q, wrap, illegal} !== {it.q, it.wrap, it.ill}) begin
      errors++;
      $display("FAIL async_reset_release: q/wrap/illegal got %b/%b/%b want %b/%b/%b", q, wrap, illegal, it.q, it.wrap, it.ill);
    end
  endtask

  initial begin
    test_reset();
    test_ring_up();
    test_johnson_up();
    test_ring_down();
    test_illegal();
    test_load_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
